// File: rtl/aes_pkg.sv
// Shared AES constants and GF(2^8) helpers for the round-stage datapath.
// Byte i of a block sits at bits [127-8i -: 8]; row = i mod 4, column = i div 4.
package aes_pkg;

    localparam int AES_BLK_W = 128;
    localparam logic [7:0] AES_RED = 8'h1B;

    // MSB position of the byte at (row r, column c) in a 128-bit block.
    function automatic int byte_off(input int r, input int c);
        return AES_BLK_W - 1 - 8 * (4 * c + r);
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? AES_RED : 8'h00);
    endfunction

    function automatic logic [7:0] mul2(input logic [7:0] x);
        return xtime(x);
    endfunction

    function automatic logic [7:0] mul3(input logic [7:0] x);
        return xtime(x) ^ x;
    endfunction

endpackage

// File: rtl/mix_column.sv
// Combinational MixColumns for one 32-bit column; row 0 is the top byte.
module mix_column
    import aes_pkg::*;
(
    input  logic [31:0] col_in,
    output logic [31:0] col_out
);

    logic [7:0] a0, a1, a2, a3;

    assign {a0, a1, a2, a3} = col_in;

    assign col_out = {
        mul2(a0) ^ mul3(a1) ^ a2       ^ a3,
        a0       ^ mul2(a1) ^ mul3(a2) ^ a3,
        a0       ^ a1       ^ mul2(a2) ^ mul3(a3),
        mul3(a0) ^ a1       ^ a2       ^ mul2(a3)
    };

endmodule

// File: rtl/shiftmix_stage.sv
// AES ShiftRows + MixColumns round stage with a registered output and an
// optional 2-entry skid buffer so the round pipeline sustains one block per clock.
module shiftmix_stage
    import aes_pkg::*;
#(
    parameter int TAG_W   = 4,
    parameter bit SKID_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [AES_BLK_W-1:0] in_data,
    input  logic                 in_last,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [AES_BLK_W-1:0] out_data,
    output logic                 out_last,
    output logic [TAG_W-1:0]     out_tag
);

    logic [AES_BLK_W-1:0] shifted;
    logic [AES_BLK_W-1:0] mixed;
    logic [AES_BLK_W-1:0] result;

    logic                 skid_valid;
    logic [AES_BLK_W-1:0] skid_data;
    logic                 skid_last;
    logic [TAG_W-1:0]     skid_tag;

    logic accept;
    logic main_free;

    // NOTE: every variable in always_comb gets a default first so no latch is inferred.
    always_comb begin
        shifted = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                shifted[byte_off(r, c) -: 8] = in_data[byte_off(r, (c + r) % 4) -: 8];
            end
        end
    end

    for (genvar c = 0; c < 4; c++) begin : g_mix
        mix_column u_mix (
            .col_in  (shifted[AES_BLK_W-1-32*c -: 32]),
            .col_out (mixed[AES_BLK_W-1-32*c -: 32])
        );
    end

    assign result = in_last ? shifted : mixed;

    // With the skid enabled, in_ready depends only on registered state (and reset).
    assign in_ready  = SKID_EN ? (~skid_valid & ~rst) : ((out_ready | ~out_valid) & ~rst);
    assign accept    = in_valid & in_ready;
    assign main_free = ~out_valid | out_ready;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_last   <= 1'b0;
            out_tag    <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_last  <= 1'b0;
            skid_tag   <= '0;
        end else if (main_free) begin
            if (skid_valid) begin
                // Skid holds the older block; in_ready was low, so nothing new arrives now.
                out_valid  <= 1'b1;
                out_data   <= skid_data;
                out_last   <= skid_last;
                out_tag    <= skid_tag;
                skid_valid <= 1'b0;
            end else if (accept) begin
                out_valid <= 1'b1;
                out_data  <= result;
                out_last  <= in_last;
                out_tag   <= in_tag;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (SKID_EN && accept) begin
            skid_valid <= 1'b1;
            skid_data  <= result;
            skid_last  <= in_last;
            skid_tag   <= in_tag;
        end
    end

endmodule

// File: tb/tb_shiftmix_stage.sv
// Self-checking bench for shiftmix_stage: directed FIPS-197 vectors, handshake
// scenarios and a randomized stream, all scored against a byte-matrix AES model.
module tb_shiftmix_stage;

    localparam int TAG_W = 4;

    typedef struct packed {
        logic [127:0]     d;
        logic             l;
        logic [TAG_W-1:0] t;
    } blk_t;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [127:0]     in_data;
    logic             in_last;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [127:0]     out_data;
    logic             out_last;
    logic [TAG_W-1:0] out_tag;

    int   total = 0;
    int   bad = 0;
    int   popped = 0;
    blk_t q[$];
    blk_t hold;
    bit   have_hold = 1'b0;

    shiftmix_stage #(.TAG_W(TAG_W), .SKID_EN(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_tag   (out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Generic GF(2^8) multiply: carry-less product then reduction by 0x11B.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] k);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++)
            if (k[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--)
            if (p[i]) p = p ^ (16'h011B << (i - 8));
        return p[7:0];
    endfunction

    // Reference round: state as a 4x4 byte matrix [row][col].
    function automatic logic [127:0] ref_round(input logic [127:0] x, input logic last);
        logic [7:0]   s[4][4];
        logic [7:0]   t[4][4];
        logic [7:0]   a[4];
        logic [127:0] y;
        for (int i = 0; i < 16; i++) s[i % 4][i / 4] = x[127 - 8 * i -: 8];
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                t[r][c] = s[r][(c + r) % 4];
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                for (int r = 0; r < 4; r++) a[r] = t[r][c];
                for (int r = 0; r < 4; r++)
                    t[r][c] = gmul(a[r], 8'd2) ^ gmul(a[(r + 1) % 4], 8'd3)
                            ^ a[(r + 2) % 4] ^ a[(r + 3) % 4];
            end
        end
        y = '0;
        for (int i = 0; i < 16; i++) y[127 - 8 * i -: 8] = t[i % 4][i / 4];
        return y;
    endfunction

    // Scoreboard: occupancy of the model queue predicts out_valid and in_ready.
    always @(negedge clk) begin
        if (rst) begin
            check1("in_ready_during_rst", in_ready, 1'b0);
            q.delete();
            have_hold = 1'b0;
        end else begin
            check1("out_valid_vs_model", out_valid, q.size() > 0);
            check1("in_ready_vs_model", in_ready, q.size() < 2);
            if (out_valid && q.size() > 0) begin
                check("out_data_vs_model", out_data, q[0].d);
                check1("out_last_vs_model", out_last, q[0].l);
                check("out_tag_vs_model", 128'(out_tag), 128'(q[0].t));
            end
            if (have_hold && out_valid) begin
                check("stall_data_stable", out_data, hold.d);
                check("stall_tag_stable", 128'(out_tag), 128'(hold.t));
            end
            if (out_valid && out_ready) begin
                if (q.size() > 0) void'(q.pop_front());
                popped++;
            end
            have_hold = out_valid && !out_ready;
            hold = '{d: out_data, l: out_last, t: out_tag};
            if (in_valid && in_ready)
                q.push_back('{d: ref_round(in_data, in_last), l: in_last, t: in_tag});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_data();
        in_data = {$urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        int cyc;
        int p0;

        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        in_last = 1'b0;
        in_tag = '0;
        out_ready = 1'b0;

        // Pin the model with the FIPS-197 Appendix B round 1 values.
        check("model_mix", ref_round(128'hd42711aee0bf98f1b8b45de51e415230, 1'b0),
              128'h046681e5e0cb199a48f8d37a2806264c);
        check("model_shift_only", ref_round(128'hd42711aee0bf98f1b8b45de51e415230, 1'b1),
              128'hd4bf5d30e0b452aeb84111f11e2798e5);

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check1("reset_out_valid", out_valid, 1'b0);
        check("reset_out_data", out_data, 128'h0);
        check1("reset_out_last", out_last, 1'b0);
        check("reset_out_tag", 128'(out_tag), 128'h0);
        check1("reset_in_ready", in_ready, 1'b1);

        // FIPS vector, full round, one-cycle latency.
        tick();
        in_valid = 1'b1;
        in_data = 128'hd42711aee0bf98f1b8b45de51e415230;
        in_last = 1'b0;
        in_tag = 4'd5;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check1("fips_out_valid", out_valid, 1'b1);
        check("fips_out_data", out_data, 128'h046681e5e0cb199a48f8d37a2806264c);
        check1("fips_out_last", out_last, 1'b0);
        check("fips_out_tag", 128'(out_tag), 128'h5);

        // Same block as a final round: ShiftRows only.
        tick();
        in_valid = 1'b1;
        in_last = 1'b1;
        in_tag = 4'd6;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check1("last_out_valid", out_valid, 1'b1);
        check("last_out_data", out_data, 128'hd4bf5d30e0b452aeb84111f11e2798e5);
        check1("last_out_last", out_last, 1'b1);
        check("last_out_tag", 128'(out_tag), 128'h6);

        // Back-to-back stream of 8 blocks at full rate.
        for (int i = 0; i < 8; i++) begin
            tick();
            in_valid = 1'b1;
            in_tag = TAG_W'(i);
            in_last = i[0];
            rand_data();
            @(negedge clk);
            check1("stream_in_ready", in_ready, 1'b1);
            if (i > 0) begin
                check1("stream_out_valid", out_valid, 1'b1);
                check("stream_out_tag", 128'(out_tag), 128'(i - 1));
            end
        end
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check1("stream_tail_valid", out_valid, 1'b1);
        check("stream_tail_tag", 128'(out_tag), 128'h7);

        // Stall: main and skid fill, third block is held off.
        tick();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_last = 1'b0;
        in_tag = 4'd8;
        rand_data();
        @(negedge clk);
        check1("stall_empty_valid", out_valid, 1'b0);
        check1("stall_ready0", in_ready, 1'b1);
        tick();
        in_tag = 4'd9;
        rand_data();
        @(negedge clk);
        check1("stall_ready1", in_ready, 1'b1);
        check("stall_main_tag", 128'(out_tag), 128'h8);
        tick();
        in_tag = 4'd10;
        rand_data();
        @(negedge clk);
        check1("stall_skid_full", in_ready, 1'b0);
        check("stall_hold_tag_a", 128'(out_tag), 128'h8);
        tick();
        @(negedge clk);
        check1("stall_still_full", in_ready, 1'b0);
        check("stall_hold_tag_b", 128'(out_tag), 128'h8);
        tick();
        out_ready = 1'b1;
        @(negedge clk);
        check1("release_ready_still_low", in_ready, 1'b0);
        tick();
        @(negedge clk);
        check("release_tag_9", 128'(out_tag), 128'h9);
        check1("release_ready_up", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("release_tag_10", 128'(out_tag), 128'ha);
        check1("release_valid_10", out_valid, 1'b1);
        tick();
        @(negedge clk);
        check1("release_drained", out_valid, 1'b0);

        // Reset with both main and skid occupied.
        tick();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_tag = 4'd1;
        rand_data();
        tick();
        in_tag = 4'd2;
        rand_data();
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check1("full_before_rst_ready", in_ready, 1'b0);
        check1("full_before_rst_valid", out_valid, 1'b1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check1("midrst_out_valid", out_valid, 1'b0);
        check("midrst_out_data", out_data, 128'h0);
        check("midrst_out_tag", 128'(out_tag), 128'h0);
        check1("midrst_in_ready", in_ready, 1'b1);

        // Random valid/ready toggling over 1000 accepted blocks.
        p0 = popped;
        sent = 0;
        cyc = 0;
        tick();
        while (sent < 1000 && cyc < 20000) begin
            in_valid = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            in_last = 1'($urandom_range(0, 1));
            in_tag = TAG_W'($urandom_range(0, 15));
            rand_data();
            @(negedge clk);
            if (in_valid && in_ready) sent++;
            tick();
            cyc++;
        end
        check1("random_within_budget", sent == 1000, 1'b1);
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick();
        @(negedge clk);
        check1("random_drained_empty", q.size() == 0, 1'b1);
        check("random_output_count", 128'(popped - p0), 128'(sent));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shiftmix_stage.md
Name: shiftmix_stage

Overview:
- Registered AES round stage directly downstream of the 16-S-box SubBytes datapath. Consumes the 128-bit substituted state and applies ShiftRows, then MixColumns (skipped on the final round).
- Result is registered behind a valid/ready handshake with a 2-entry skid buffer, so the pipelined encryption core runs at one block per clock with back-pressure.
- Output feeds the AddRoundKey stage.

Parameters:
- TAG_W, 4, width of the opaque sideband tag (round index / stream id) carried alongside each block.
- SKID_EN, 1, 1 = 2-entry skid buffer (in_ready registered); 0 = single register, in_ready = out_ready | ~out_valid (combinational).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  upstream block valid.
- in_ready  out  1  stage can accept; transfer when in_valid & in_ready.
- in_data  in  128  SubBytes output state.
- in_last  in  1  final round: bypass MixColumns.
- in_tag  in  TAG_W  sideband, passed through unchanged.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts; transfer when out_valid & out_ready.
- out_data  out  128  ShiftRows(+MixColumns) result.
- out_last  out  1  registered copy of in_last.
- out_tag  out  TAG_W  registered copy of in_tag.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, rst.
- Byte mapping: byte i occupies bits [127-8i -: 8]. Row r = i mod 4, column c = i div 4 (FIPS-197 column-major). Same mapping as the SubBytes stage.
- ShiftRows: out(r,c) = in(r, (c+r) mod 4). Row 0 is unchanged.
- MixColumns per column in GF(2^8), reduction polynomial 0x11B:
  - b0 = 2a0^3a1^a2^a3
  - b1 = a0^2a1^3a2^a3
  - b2 = a0^a1^2a2^3a3
  - b3 = 3a0^a1^a2^2a3
  - xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1B : 8'h00).
- in_last=1: output is ShiftRows only.
- Datapath is combinational into the output register.
- Latency: exactly 1 cycle from accept to out_valid when the output register is empty or draining. Throughput is 1 block/cycle when out_ready is held high.
- Reset: out_valid=0, out_data=0, out_last=0, out_tag=0, skid empty. in_ready=1 in the first cycle after reset is released (SKID_EN=1); in_ready=0 while rst=1.
- Skid buffer (SKID_EN=1):
  - Registers: main (out_*) and skid. in_ready = ~skid_valid, driven from a register.
  - Accept with main empty, or main draining (out_ready=1): the result loads main.
  - Accept with main full and out_ready=0: the result loads skid; in_ready drops next cycle.
  - Main drains while skid is full: skid moves to main the same cycle, skid empties, in_ready rises next cycle.
  - Simultaneous accept + drain + skid full is impossible, because in_ready=0.
- Ordering is strictly FIFO. No block is dropped or duplicated. out_* hold stable while out_valid & ~out_ready.
- Reset asserted mid-stream discards main and skid contents the next edge, with no partial output.
- in_data, in_last and in_tag are ignored when no transfer occurs.

Decomposition:
- aes_pkg holds:
  - AES_BLK_W=128
  - function byte index (r,c)->bit offset
  - xtime, mul2, mul3
  - constant 8'h1B.
- One natural sub-module: mix_column (32-bit in/out, combinational), instantiated 4 times. ShiftRows is pure wiring in the top.

Test Plan:
- FIPS-197 App. B round 1: in_data=d42711aee0bf98f1b8b45de51e415230, in_last=0, out_ready=1 -> next cycle out_valid=1, out_data=046681e5e0cb199a48f8d37a2806264c.
- Same input with in_last=1 -> out_data=d4bf5d30e0b452aeb84111f11e2798e5 (ShiftRows only), out_last=1.
- Back-to-back stream of 8 blocks, tags 0..7, out_ready=1 -> 8 outputs on consecutive cycles, tags in order, in_ready never drops.
- out_ready=0 while 3 blocks are offered -> blocks 0 (main) and 1 (skid) accepted, in_ready=0 from the cycle after block 1, block 2 held. Release out_ready -> outputs 0,1,2 in order with no loss.
- Random valid/ready toggling over 1000 blocks against a reference model -> exact match and ordering. out_* stable during stalls.
- rst=1 for 1 cycle with main and skid full -> next cycle out_valid=0, out_data=0, skid empty. in_ready=1 the cycle after rst deasserts.
